pong_match_controller: RTL and testbench

//  Match sequencer for the pong game. Owns game state (idle, serve, play, game over), lives, BCD score,

---
 rtl/pong_match_controller.sv | 179 +++++++++++++++++
 tb/tb_pong_match_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pong_match_controller.sv
// Match sequencer for the pong game: owns the idle/serve/play/game-over flow,
// lives, BCD score, speed level and the ball-move tick. It gates the engine's
// ball and reacts to the HIT/MISS events that the engine reports back.
module pong_match_controller #(
  parameter int TICK_BASE      = 91072,
  parameter int TICK_STEP      = 8192,
  parameter int MAX_LEVEL      = 7,
  parameter int HITS_PER_LEVEL = 4,
  parameter int SERVE_DELAY    = 67108864,
  parameter int LIVES_INIT     = 3
) (
  input  logic       VGA_CLOCK,
  input  logic       RESET,
  input  logic       START,
  input  logic       HIT,
  input  logic       MISS,
  output logic [1:0] STATE,
  output logic       BALL_ENABLE,
  output logic       MOVE_TICK,
  output logic       SERVE_REQ,
  output logic [7:0] SCORE_BCD,
  output logic [3:0] LIVES,
  output logic [2:0] LEVEL,
  output logic       GAME_OVER
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SERVE = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;
  localparam int         HC_W    = $clog2(HITS_PER_LEVEL + 1);

  logic [1:0]      r_state;
  logic [27:0]     r_delay;
  logic [27:0]     r_tick;
  logic [HC_W-1:0] r_hits;
  logic [7:0]      r_score;
  logic [3:0]      r_lives;
  logic [2:0]      r_level;
  logic            r_ball_en;
  logic            r_move_tick;
  logic            r_serve_req;
  logic            r_game_over;

  logic [1:0]      w_state_nxt;
  logic [27:0]     w_delay_nxt;
  logic [27:0]     w_tick_nxt;
  logic [HC_W-1:0] w_hits_nxt;
  logic [7:0]      w_score_nxt;
  logic [3:0]      w_lives_nxt;
  logic [2:0]      w_level_nxt;
  logic            w_move_nxt;
  logic            w_serve_req_nxt;
  logic            w_start_match;
  logic            w_play;
  logic            w_miss;
  logic            w_hit;
  logic            w_level_up;

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    if (v == 8'h99)          return v;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Speed level increment that sticks at the top level.
  function automatic logic [2:0] level_inc_sat(input logic [2:0] v);
    if (v == 3'(MAX_LEVEL)) return v;
    else                    return v + 3'd1;
  endfunction

  // Tick reload value (period - 1) for the given speed level.
  function automatic logic [27:0] period_m1(input logic [2:0] lvl);
    return 28'(TICK_BASE - TICK_STEP * int'(lvl) - 1);
  endfunction

  assign w_start_match = ((r_state == S_IDLE) || (r_state == S_OVER)) && START;
  assign w_play        = (r_state == S_PLAY);
  assign w_miss        = w_play && MISS;
  assign w_hit         = w_play && HIT && !MISS;
  assign w_level_up    = w_hit && (r_hits == HC_W'(HITS_PER_LEVEL - 1));

  // State register.
  always_ff @(posedge VGA_CLOCK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode; MISS takes priority over everything else in PLAY.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_OVER: if (START) w_state_nxt = S_SERVE;
      S_SERVE:        if (r_delay == 28'd0) w_state_nxt = S_PLAY;
      S_PLAY:         if (MISS) w_state_nxt = (r_lives <= 4'd1) ? S_OVER : S_SERVE;
      default:        w_state_nxt = r_state;
    endcase
  end

  // Next values for counters, score and strobes.
  always_comb begin
    w_delay_nxt     = r_delay;
    w_tick_nxt      = r_tick;
    w_hits_nxt      = r_hits;
    w_score_nxt     = r_score;
    w_lives_nxt     = r_lives;
    w_level_nxt     = r_level;
    w_move_nxt      = w_play && !MISS && (r_tick == 28'd0);
    w_serve_req_nxt = w_start_match || (w_miss && (r_lives > 4'd1));

    // Delay counter: loaded on every serve, counts down while serving.
    if (w_serve_req_nxt)
      w_delay_nxt = 28'(SERVE_DELAY - 1);
    else if ((r_state == S_SERVE) && (r_delay != 28'd0))
      w_delay_nxt = r_delay - 28'd1;

    // Tick counter: period is re-evaluated only at a reload.
    if ((r_state == S_SERVE) && (r_delay == 28'd0))
      w_tick_nxt = period_m1(r_level);
    else if (w_play && !MISS)
      w_tick_nxt = (r_tick == 28'd0) ? period_m1(r_level) : r_tick - 28'd1;

    if (w_start_match) begin
      w_score_nxt = 8'h00;
      w_hits_nxt  = '0;
      w_level_nxt = 3'd0;
      w_lives_nxt = 4'(LIVES_INIT);
    end else if (w_miss) begin
      w_lives_nxt = r_lives - 4'd1;
      w_hits_nxt  = '0;
    end else if (w_hit) begin
      w_score_nxt = bcd_inc_sat(r_score);
      if (w_level_up) begin
        w_hits_nxt  = '0;
        w_level_nxt = level_inc_sat(r_level);
      end else begin
        w_hits_nxt  = r_hits + HC_W'(1);
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge VGA_CLOCK or posedge RESET) begin
    if (RESET) begin
      r_delay     <= '0;
      r_tick      <= '0;
      r_hits      <= '0;
      r_score     <= 8'h00;
      r_lives     <= 4'(LIVES_INIT);
      r_level     <= 3'd0;
      r_ball_en   <= 1'b0;
      r_move_tick <= 1'b0;
      r_serve_req <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_delay     <= w_delay_nxt;
      r_tick      <= w_tick_nxt;
      r_hits      <= w_hits_nxt;
      r_score     <= w_score_nxt;
      r_lives     <= w_lives_nxt;
      r_level     <= w_level_nxt;
      r_ball_en   <= (w_state_nxt == S_PLAY);
      r_move_tick <= w_move_nxt;
      r_serve_req <= w_serve_req_nxt;
      r_game_over <= (w_state_nxt == S_OVER);
    end
  end

  assign STATE       = r_state;
  assign BALL_ENABLE = r_ball_en;
  assign MOVE_TICK   = r_move_tick;
  assign SERVE_REQ   = r_serve_req;
  assign SCORE_BCD   = r_score;
  assign LIVES       = r_lives;
  assign LEVEL       = r_level;
  assign GAME_OVER   = r_game_over;

endmodule

// File: tb/tb_pong_match_controller.sv
// Directed bench for pong_match_controller with small timing parameters.
module tb_pong_match_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic [1:0] state;
  logic       ball_en;
  logic       move_tick;
  logic       serve_req;
  logic [7:0] score;
  logic [3:0] lives;
  logic [2:0] level;
  logic       game_over;

  int n_checks = 0;
  int n_fail   = 0;

  pong_match_controller #(
    .TICK_BASE(16), .TICK_STEP(2), .MAX_LEVEL(3),
    .HITS_PER_LEVEL(2), .SERVE_DELAY(8), .LIVES_INIT(2)
  ) dut (
    .VGA_CLOCK(clk), .RESET(rst), .START(start), .HIT(hit), .MISS(miss),
    .STATE(state), .BALL_ENABLE(ball_en), .MOVE_TICK(move_tick),
    .SERVE_REQ(serve_req), .SCORE_BCD(score), .LIVES(lives),
    .LEVEL(level), .GAME_OVER(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Cycles until the next MOVE_TICK sample, bounded.
  task automatic wait_tick(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!move_tick && k < 200);
  endtask

  // Counts STATE==1 samples starting at the current one, bounded.
  task automatic count_serve(output int c);
    c = 0;
    while (state == 2'd1 && c < 100) begin
      c++;
      @(negedge clk);
    end
  endtask

  // Invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("tick_excl", {31'd0, move_tick & (serve_req | (state != 2'd2))}, 32'd0);
      check("ball_en_play", {31'd0, ball_en}, {31'd0, state == 2'd2});
      check("go_flag", {31'd0, game_over}, {31'd0, state == 2'd3});
    end
  end

  initial begin
    int k;
    int c;

    // Reset values
    step(2);
    check("rst_state", state, 0);
    check("rst_ball", ball_en, 0);
    check("rst_tick", move_tick, 0);
    check("rst_sreq", serve_req, 0);
    check("rst_score", score, 0);
    check("rst_lives", lives, 2);
    check("rst_level", level, 0);
    check("rst_go", game_over, 0);
    rst = 1'b0;
    step(2);

    // 1: start, serve length, tick spacing
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("s1_state", state, 1);
    check("s1_sreq", serve_req, 1);
    check("s1_lives", lives, 2);
    count_serve(c);
    check("s1_serve_len", c, 8);
    check("s1_play", state, 2);
    check("s1_ball", ball_en, 1);
    wait_tick(k);
    check("s1_first_tick", k, 16);
    wait_tick(k);
    check("s1_spacing", k, 16);

    // 2: two hits raise the level; running count is not cut
    step(4);
    hit = 1'b1;
    step(2);
    hit = 1'b0;
    check("s2_score", score, 8'h02);
    check("s2_level", level, 1);
    wait_tick(k);
    check("s2_remaining", k, 10);
    wait_tick(k);
    check("s2_spacing", k, 14);

    // 3: HIT+MISS together on the cycle a tick was due
    step(13);
    hit = 1'b1;
    miss = 1'b1;
    step(1);
    hit = 1'b0;
    miss = 1'b0;
    check("s3_score", score, 8'h02);
    check("s3_lives", lives, 1);
    check("s3_state", state, 1);
    check("s3_sreq", serve_req, 1);
    check("s3_notick", move_tick, 0);
    check("s3_level", level, 1);
    // inputs during SERVE are ignored and do not change its length
    start = 1'b1;
    hit = 1'b1;
    miss = 1'b1;
    step(1);
    start = 1'b0;
    hit = 1'b0;
    miss = 1'b0;
    check("s6_srv_state", state, 1);
    check("s6_srv_score", score, 8'h02);
    check("s6_srv_lives", lives, 1);
    check("s6_srv_sreq", serve_req, 0);
    count_serve(c);
    check("s6_srv_len", c + 1, 8);
    check("s3_play", state, 2);

    // 4: 103 more hits -> 105 total, BCD carry and saturation
    hit = 1'b1;
    step(7);
    check("s4_score09", score, 8'h09);
    step(1);
    check("s4_score10", score, 8'h10);
    step(95);
    hit = 1'b0;
    check("s4_score99", score, 8'h99);
    check("s4_level", level, 3);
    wait_tick(k);
    wait_tick(k);
    check("s4_spacing", k, 10);

    // 5: last life lost, then restart from GAME_OVER
    miss = 1'b1;
    step(1);
    miss = 1'b0;
    check("s5_state", state, 3);
    check("s5_go", game_over, 1);
    check("s5_lives", lives, 0);
    check("s5_ball", ball_en, 0);
    hit = 1'b1;
    step(3);
    hit = 1'b0;
    check("s5_hold_score", score, 8'h99);
    check("s5_hold_level", level, 3);
    check("s5_hold_state", state, 3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("s5_rs_score", score, 8'h00);
    check("s5_rs_lives", lives, 2);
    check("s5_rs_level", level, 0);
    check("s5_rs_state", state, 1);
    check("s5_rs_sreq", serve_req, 1);

    // 6: asynchronous reset in the middle of PLAY
    count_serve(c);
    check("s6_serve_len", c, 8);
    hit = 1'b1;
    step(1);
    hit = 1'b0;
    check("s6_score", score, 8'h01);
    step(5);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("s6_rst_state", state, 0);
    check("s6_rst_ball", ball_en, 0);
    check("s6_rst_tick", move_tick, 0);
    check("s6_rst_sreq", serve_req, 0);
    check("s6_rst_score", score, 0);
    check("s6_rst_lives", lives, 2);
    check("s6_rst_level", level, 0);
    check("s6_rst_go", game_over, 0);
    step(2);
    rst = 1'b0;
    step(2);
    hit = 1'b1;
    miss = 1'b1;
    step(1);
    hit = 1'b0;
    miss = 1'b0;
    step(1);
    check("idle_state", state, 0);
    check("idle_score", score, 0);
    check("idle_lives", lives, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
